// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the serial program loader: FSM state encoding, the
// width of the little-endian length header, byte-packer terminal counts and a
// helper that judges whether a length header is legal.
// -----------------------------------------------------------------------------
package loader_pkg;

    // Width of the word-count header that precedes the program image.
    localparam int HDR_W = 16;

    // Index of the last byte of a header (2 bytes) and of an instruction (4 bytes).
    localparam logic [1:0] LEN_LAST  = 2'd1;
    localparam logic [1:0] DATA_LAST = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // A header is illegal when it asks for no words or more than the memory holds.
    function automatic logic hdr_illegal(input logic [HDR_W-1:0] cnt,
                                         input logic [HDR_W-1:0] max_words);
        return (cnt == {HDR_W{1'b0}}) || (cnt > max_words);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Little-endian byte-to-word assembler. Each accepted byte is shifted in from
// the top, so after four bytes the first one sits in bits 7:0. For the two-byte
// length header the assembled value appears in bits 31:16.
//
// Ports
//   clk_i          clock
//   areset_i       synchronous active-high reset
//   clr_i          restart assembly (drops any partial word)
//   byte_en_i      a byte is accepted this cycle
//   byte_data_i    the byte being accepted
//   last_idx_i     index of the final byte of the current word (1 or 3)
//   word_o         assembled word including the byte accepted this cycle
//   word_valid_o   one-cycle pulse: the final byte is accepted this cycle
// -----------------------------------------------------------------------------
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        areset_i,
    input  logic        clr_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_data_i,
    input  logic [1:0]  last_idx_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    // Next shift register / byte counter and the completion pulse.
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        word_valid_o = 1'b0;
        if (clr_i) begin
            shift_d = 32'd0;
            cnt_d   = 2'd0;
        end else if (byte_en_i) begin
            shift_d = {byte_data_i, shift_q[31:8]};
            if (cnt_q == last_idx_i) begin
                cnt_d        = 2'd0;
                word_valid_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end else begin
            shift_d = shift_q;
            cnt_d   = cnt_q;
        end
    end

    // The word is presented combinationally so the loader can act on the
    // same edge that accepts the final byte.
    assign word_o = shift_d;

    // Shift register and byte counter state.
    always_ff @(posedge clk_i) begin
        if (areset_i) begin
            shift_q <= 32'd0;
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Receives a program over a byte stream (16-bit little-endian word count,
// then little-endian 32-bit instructions), writes it into instruction memory
// and then releases the core. All outputs are registered and decoded from the
// next state, so they always agree with the state the FSM is in.
//
// Ports
//   clk          clock, rising edge
//   areset       synchronous active-high reset
//   start        one-cycle request to begin a load (ignored while loading)
//   byte_valid   byte_data holds a valid byte
//   byte_data    serial program byte
//   byte_ready   loader accepts a byte this cycle (LEN and DATA only)
//   imem_we      instruction-memory write strobe
//   imem_addr    word address of the write
//   imem_wdata   instruction word to write
//   core_rst     holds the datapath in reset (all states but RUN)
//   pc_load      PC update enable (RUN only)
//   busy         load in progress (LEN, DATA, WRITE)
//   done         program loaded and core running (RUN only)
//   err          illegal length header seen (ERR only)
// -----------------------------------------------------------------------------
module prog_loader
    import loader_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              pc_load,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [HDR_W-1:0] MAX_WORDS = HDR_W'(MEM_WORDS);

    state_t            state_q, state_d;
    logic [HDR_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] widx_q, widx_d;

    logic              byte_ready_q, byte_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              pc_load_q, pc_load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept_s;
    logic              pk_clr_s;
    logic [1:0]        pk_last_s;
    logic [31:0]       pk_word_s;
    logic              pk_valid_s;
    logic [HDR_W-1:0]  hdr_s;
    logic              last_word_s;

    // byte_ready_q mirrors "state is LEN or DATA", so it doubles as the handshake gate.
    assign accept_s  = byte_valid & byte_ready_q;
    assign pk_last_s = (state_q == ST_LEN) ? LEN_LAST : DATA_LAST;
    // Two bytes shifted in from the top leave the header in the upper half.
    assign hdr_s     = pk_word_s[31 -: HDR_W];
    assign last_word_s = ((HDR_W'(widx_q) + HDR_W'(1'b1)) == count_q);

    byte_packer u_packer (
        .clk_i        (clk),
        .areset_i     (areset),
        .clr_i        (pk_clr_s),
        .byte_en_i    (accept_s),
        .byte_data_i  (byte_data),
        .last_idx_i   (pk_last_s),
        .word_o       (pk_word_s),
        .word_valid_o (pk_valid_s)
    );

    // Next-state logic: header/word completion drives the transitions.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        widx_d   = widx_q;
        pk_clr_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    state_d  = ST_LEN;
                    count_d  = {HDR_W{1'b0}};
                    widx_d   = {ADDR_W{1'b0}};
                    pk_clr_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN: begin
                if (pk_valid_s) begin
                    count_d = hdr_s;
                    widx_d  = {ADDR_W{1'b0}};
                    if (hdr_illegal(hdr_s, MAX_WORDS)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_DATA: begin
                if (pk_valid_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (last_word_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DATA;
                    widx_d  = widx_q + ADDR_W'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = {HDR_W{1'b0}};
                widx_d  = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with state_q.
    always_comb begin
        byte_ready_d = 1'b0;
        imem_we_d    = 1'b0;
        imem_addr_d  = {ADDR_W{1'b0}};
        imem_wdata_d = 32'd0;
        core_rst_d   = 1'b1;
        pc_load_d    = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_d)
            ST_LEN, ST_DATA: begin
                byte_ready_d = 1'b1;
                busy_d       = 1'b1;
            end
            ST_WRITE: begin
                // WRITE is only entered on the edge that completes a word,
                // so the packer output is the instruction to store.
                imem_we_d    = 1'b1;
                imem_addr_d  = widx_d;
                imem_wdata_d = pk_word_s;
                busy_d       = 1'b1;
            end
            ST_RUN: begin
                core_rst_d = 1'b0;
                pc_load_d  = 1'b1;
                done_d     = 1'b1;
            end
            ST_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                core_rst_d = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            count_q      <= {HDR_W{1'b0}};
            widx_q       <= {ADDR_W{1'b0}};
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= {ADDR_W{1'b0}};
            imem_wdata_q <= 32'd0;
            core_rst_q   <= 1'b1;
            pc_load_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            widx_q       <= widx_d;
            byte_ready_q <= byte_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            pc_load_q    <= pc_load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign pc_load    = pc_load_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Table-driven check of prog_loader: each row applies one cycle of inputs and
// states which loader state must follow; the expected outputs of that state
// come from the loader's output definitions. Hand-written sequences cover the
// stalled stream and reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam logic [2:0] E_IDLE = 3'd0, E_LEN = 3'd1, E_DATA = 3'd2,
                           E_WRITE = 3'd3, E_RUN = 3'd4, E_ERR = 3'd5;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, imem_we, core_rst, pc_load, busy, done, err;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        st;
        logic        bv;
        logic [7:0]  bd;
        logic [2:0]  es;
        logic [5:0]  ea;
        logic [31:0] ew;
    } vec_t;

    vec_t        vecs[$];
    logic [37:0] wr_q[$];

    prog_loader #(.MEM_WORDS(64), .ADDR_W(6)) dut (
        .clk        (clk),
        .areset     (areset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .pc_load    (pc_load),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic st, input logic bv, input logic [7:0] bd,
                       input logic [2:0] es, input logic [5:0] ea, input logic [31:0] ew);
        vec_t v;
        v.rst = rst; v.st = st; v.bv = bv; v.bd = bd; v.es = es; v.ea = ea; v.ew = ew;
        vecs.push_back(v);
    endtask

    task automatic cyc(input logic rst, input logic st, input logic bv, input logic [7:0] bd);
        @(negedge clk);
        areset = rst; start = st; byte_valid = bv; byte_data = bd;
        @(posedge clk);
        #1;
    endtask

    // Outputs as a bundle: rdy, we, addr, wdata, core_rst, pc_load, busy, done, err.
    function automatic logic [63:0] act_bundle(input logic care);
        return 64'({byte_ready, imem_we, (care ? imem_addr : 6'd0), (care ? imem_wdata : 32'd0),
                    core_rst, pc_load, busy, done, err});
    endfunction

    function automatic logic [63:0] exp_bundle(input logic [2:0] es, input logic care,
                                               input logic [5:0] ea, input logic [31:0] ew);
        logic rdy, we, cr, pc, bs, dn, er;
        rdy = 1'b0; we = 1'b0; cr = 1'b1; pc = 1'b0; bs = 1'b0; dn = 1'b0; er = 1'b0;
        case (es)
            E_LEN, E_DATA: begin rdy = 1'b1; bs = 1'b1; end
            E_WRITE:       begin we = 1'b1; bs = 1'b1; end
            E_RUN:         begin cr = 1'b0; pc = 1'b1; dn = 1'b1; end
            E_ERR:         begin er = 1'b1; end
            default:       begin cr = 1'b1; end
        endcase
        return 64'({rdy, we, (care ? ea : 6'd0), (care ? ew : 32'd0), cr, pc, bs, dn, er});
    endfunction

    initial begin : main
        logic [7:0] s2[10];
        logic       care;
        s2 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};

        // --- table: two-word load, reload, errors, boundaries ---
        add(1, 0, 0, 8'h00, E_IDLE, 6'd0, 32'h0);
        add(0, 1, 0, 8'h00, E_LEN, 6'd0, 32'h0);
        add(0, 0, 1, 8'h02, E_LEN, 6'd0, 32'h0);
        add(0, 0, 1, 8'h00, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'h13, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'h00, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'h50, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'h00, E_WRITE, 6'd0, 32'h00500013);
        add(0, 0, 1, 8'hFF, E_DATA, 6'd0, 32'h0);   // byte offered in WRITE is not taken
        add(0, 0, 0, 8'h00, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'h93, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'h00, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'hA0, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'h00, E_WRITE, 6'd1, 32'h00A00093);
        add(0, 0, 0, 8'h00, E_RUN, 6'd0, 32'h0);
        add(0, 0, 0, 8'h00, E_RUN, 6'd0, 32'h0);
        add(0, 1, 0, 8'h00, E_LEN, 6'd0, 32'h0);    // restart from RUN
        add(0, 0, 1, 8'h01, E_LEN, 6'd0, 32'h0);
        add(0, 0, 1, 8'h00, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'hEF, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'hBE, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'hAD, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'hDE, E_WRITE, 6'd0, 32'hDEADBEEF);
        add(0, 0, 0, 8'h00, E_RUN, 6'd0, 32'h0);
        add(0, 1, 0, 8'h00, E_LEN, 6'd0, 32'h0);
        add(0, 0, 1, 8'h00, E_LEN, 6'd0, 32'h0);
        add(0, 0, 1, 8'h00, E_ERR, 6'd0, 32'h0);    // zero-length header
        add(0, 0, 1, 8'h12, E_ERR, 6'd0, 32'h0);
        add(0, 0, 0, 8'h00, E_ERR, 6'd0, 32'h0);
        add(0, 1, 0, 8'h00, E_LEN, 6'd0, 32'h0);
        add(0, 0, 1, 8'h01, E_LEN, 6'd0, 32'h0);
        add(0, 0, 1, 8'h00, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'h78, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'h56, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'h34, E_DATA, 6'd0, 32'h0);
        add(0, 0, 1, 8'h12, E_WRITE, 6'd0, 32'h12345678);
        add(0, 0, 0, 8'h00, E_RUN, 6'd0, 32'h0);
        add(0, 1, 0, 8'h00, E_LEN, 6'd0, 32'h0);
        add(0, 1, 1, 8'h41, E_LEN, 6'd0, 32'h0);    // start in LEN ignored, byte taken
        add(0, 0, 1, 8'h00, E_ERR, 6'd0, 32'h0);    // 65 > 64
        add(1, 1, 0, 8'h00, E_IDLE, 6'd0, 32'h0);   // reset beats start
        add(0, 1, 0, 8'h00, E_LEN, 6'd0, 32'h0);
        add(0, 0, 1, 8'h40, E_LEN, 6'd0, 32'h0);
        add(0, 0, 1, 8'h00, E_DATA, 6'd0, 32'h0);   // 64 is legal
        add(1, 0, 0, 8'h00, E_IDLE, 6'd0, 32'h0);
        add(0, 1, 0, 8'h00, E_LEN, 6'd0, 32'h0);
        add(0, 0, 1, 8'h00, E_LEN, 6'd0, 32'h0);
        add(0, 0, 1, 8'h01, E_ERR, 6'd0, 32'h0);    // 256 via high byte
        add(0, 0, 0, 8'h00, E_ERR, 6'd0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].st, vecs[i].bv, vecs[i].bd);
            care = (vecs[i].es == E_WRITE) || vecs[i].rst;
            chk($sformatf("vec%0d", i), act_bundle(care),
                exp_bundle(vecs[i].es, care, vecs[i].ea, vecs[i].ew));
        end

        // --- stalled stream: 3 idle cycles after every byte ---
        cyc(1, 0, 0, 8'h00);
        wr_q.delete();
        cyc(0, 1, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, s2[i]);
            repeat (3) cyc(0, 0, 0, 8'h00);
        end
        for (int k = 0; k < 8 && !done; k++) cyc(0, 0, 0, 8'h00);
        chk("stall_done", 64'(done), 64'd1);
        chk("stall_nwr", 64'(wr_q.size()), 64'd2);
        if (wr_q.size() == 2) begin
            chk("stall_wr0", 64'(wr_q[0]), 64'({6'd0, 32'h00500013}));
            chk("stall_wr1", 64'(wr_q[1]), 64'({6'd1, 32'h00A00093}));
        end

        // --- reset after the 6th byte of a two-word load ---
        cyc(1, 0, 0, 8'h00);
        wr_q.delete();
        cyc(0, 1, 0, 8'h00);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, s2[i]);
        chk("mid_write", act_bundle(1'b1), exp_bundle(E_WRITE, 1'b1, 6'd0, 32'h00500013));
        cyc(1, 0, 0, 8'h00);
        chk("mid_reset", act_bundle(1'b1), exp_bundle(E_IDLE, 1'b1, 6'd0, 32'h0));
        for (int i = 6; i < 10; i++) cyc(0, 0, 1, s2[i]);
        repeat (3) cyc(0, 0, 0, 8'h00);
        chk("mid_idle", act_bundle(1'b1), exp_bundle(E_IDLE, 1'b1, 6'd0, 32'h0));
        chk("mid_nwr", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() >= 1) chk("mid_wr0", 64'(wr_q[0]), 64'({6'd0, 32'h00500013}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
